// File: rtl/map_engine.sv
// Small associative key/value map with single-cycle INSERT/DELETE/LOOKUP/CLEAR
// and a one-deep valid/ready response register.
module map_engine #(
    parameter  int KEY_WIDTH   = 8,
    parameter  int VALUE_WIDTH = 16,
    parameter  int MAP_SIZE    = 16,
    localparam int IDX_W       = $clog2(MAP_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   valid_in,
    output logic                   ready_out,
    input  logic [2:0]             op,
    input  logic [KEY_WIDTH-1:0]   key_in,
    input  logic [VALUE_WIDTH-1:0] value_in,
    output logic                   valid_out,
    input  logic                   ready_in,
    output logic [VALUE_WIDTH-1:0] value_out,
    output logic [1:0]             status_out,
    output logic [IDX_W-1:0]       index_out,
    output logic [IDX_W:0]         count_out,
    output logic                   full,
    output logic                   empty
);

    typedef enum logic [2:0] {
        OP_NOP    = 3'b000,
        OP_INSERT = 3'b001,
        OP_DELETE = 3'b010,
        OP_LOOKUP = 3'b011,
        OP_CLEAR  = 3'b100
    } op_t;

    typedef enum logic [1:0] {
        ST_OK        = 2'b00,
        ST_UPDATED   = 2'b01,
        ST_NOT_FOUND = 2'b10,
        ST_FULL      = 2'b11
    } status_t;

    localparam logic [IDX_W:0] FULL_COUNT = (IDX_W + 1)'(MAP_SIZE);

    logic [KEY_WIDTH-1:0]   key_mem [MAP_SIZE];
    logic [VALUE_WIDTH-1:0] val_mem [MAP_SIZE];
    logic [MAP_SIZE-1:0]    slot_valid;

    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             accept;
    logic             responds;

    assign ready_out = ~valid_out | ready_in;
    assign accept    = valid_in & ready_out;
    assign responds  = (op == OP_INSERT) || (op == OP_DELETE) ||
                       (op == OP_LOOKUP) || (op == OP_CLEAR);

    // Descending scan so the lowest matching / lowest free slot wins.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAP_SIZE - 1; i >= 0; i--) begin
            if (slot_valid[i] && (key_mem[i] == key_in)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!slot_valid[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            slot_valid <= '0;
            count_out  <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            valid_out  <= 1'b0;
            value_out  <= '0;
            status_out <= ST_OK;
            index_out  <= '0;
        end else begin
            if (valid_out && ready_in) begin
                valid_out <= 1'b0;
            end

            if (accept && responds) begin
                valid_out  <= 1'b1;
                value_out  <= '0;
                index_out  <= '0;
                status_out <= ST_OK;

                case (op)
                    OP_INSERT: begin
                        if (hit) begin
                            val_mem[hit_idx] <= value_in;
                            value_out        <= val_mem[hit_idx];
                            index_out        <= hit_idx;
                            status_out       <= ST_UPDATED;
                        end else if (free_found) begin
                            key_mem[free_idx]    <= key_in;
                            val_mem[free_idx]    <= value_in;
                            slot_valid[free_idx] <= 1'b1;
                            index_out            <= free_idx;
                            count_out            <= count_out + 1'b1;
                            full                 <= ((count_out + 1'b1) == FULL_COUNT);
                            empty                <= 1'b0;
                        end else begin
                            status_out <= ST_FULL;
                        end
                    end
                    OP_DELETE: begin
                        if (hit) begin
                            slot_valid[hit_idx] <= 1'b0;
                            value_out           <= val_mem[hit_idx];
                            index_out           <= hit_idx;
                            count_out           <= count_out - 1'b1;
                            full                <= 1'b0;
                            empty               <= (count_out == (IDX_W + 1)'(1));
                        end else begin
                            status_out <= ST_NOT_FOUND;
                        end
                    end
                    OP_LOOKUP: begin
                        if (hit) begin
                            value_out <= val_mem[hit_idx];
                            index_out <= hit_idx;
                        end else begin
                            status_out <= ST_NOT_FOUND;
                        end
                    end
                    OP_CLEAR: begin
                        // Stale keys/values stay in storage; only valid bits matter.
                        slot_valid <= '0;
                        count_out  <= '0;
                        full       <= 1'b0;
                        empty      <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_map_engine.sv
// Directed bench for map_engine: a reference map model fills a scoreboard queue
// as requests are accepted; a monitor pops and compares each consumed response.
module tb_map_engine;

    localparam int KW = 8;
    localparam int VW = 16;
    localparam int MS = 16;
    localparam int IW = 4;

    localparam logic [2:0] NOP = 3'b000;
    localparam logic [2:0] INS = 3'b001;
    localparam logic [2:0] DEL = 3'b010;
    localparam logic [2:0] LKP = 3'b011;
    localparam logic [2:0] CLR = 3'b100;

    logic          clk;
    logic          reset_n;
    logic          valid_in;
    logic          ready_out;
    logic [2:0]    op;
    logic [KW-1:0] key_in;
    logic [VW-1:0] value_in;
    logic          valid_out;
    logic          ready_in;
    logic [VW-1:0] value_out;
    logic [1:0]    status_out;
    logic [IW-1:0] index_out;
    logic [IW:0]   count_out;
    logic          full;
    logic          empty;

    map_engine #(
        .KEY_WIDTH   (KW),
        .VALUE_WIDTH (VW),
        .MAP_SIZE    (MS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .op         (op),
        .key_in     (key_in),
        .value_in   (value_in),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .value_out  (value_out),
        .status_out (status_out),
        .index_out  (index_out),
        .count_out  (count_out),
        .full       (full),
        .empty      (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]    status;
        logic [VW-1:0] value;
        logic [IW-1:0] index;
    } resp_t;

    resp_t         exp_q[$];
    logic [KW-1:0] m_key [MS];
    logic [VW-1:0] m_val [MS];
    bit            m_vld [MS];
    int            m_count;
    int            checks   = 0;
    int            failures = 0;

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        resp_t e;
        checkValue("resp_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkValue("resp_status", 32'(status_out), 32'(e.status));
            checkValue("resp_value",  32'(value_out),  32'(e.value));
            checkValue("resp_index",  32'(index_out),  32'(e.index));
        end
    endtask

    always @(negedge clk) begin
        if (reset_n === 1'b1 && valid_out === 1'b1 && ready_in === 1'b1) begin
            checkOutput();
        end
    end

    task automatic modelClear();
        for (int i = 0; i < MS; i++) m_vld[i] = 1'b0;
        m_count = 0;
    endtask

    // Drives one request, waits (bounded) for acceptance, updates the model and
    // pushes the expected response; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [2:0] o, input logic [KW-1:0] k, input logic [VW-1:0] v);
        int    guard;
        int    hit;
        int    free;
        resp_t e;
        valid_in = 1'b1;
        op       = o;
        key_in   = k;
        value_in = v;
        guard    = 0;
        @(negedge clk);
        while (!ready_out && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkValue("accept_ready", 32'(ready_out), 32'd1);
        if (ready_out) begin
            hit  = -1;
            free = -1;
            for (int i = 0; i < MS; i++) if (m_vld[i] && m_key[i] == k) hit = i;
            for (int i = MS - 1; i >= 0; i--) if (!m_vld[i]) free = i;
            e = '0;
            case (o)
                INS: begin
                    if (hit >= 0) begin
                        e.status   = 2'b01;
                        e.value    = m_val[hit];
                        e.index    = hit[IW-1:0];
                        m_val[hit] = v;
                    end else if (free >= 0) begin
                        e.index     = free[IW-1:0];
                        m_vld[free] = 1'b1;
                        m_key[free] = k;
                        m_val[free] = v;
                        m_count++;
                    end else begin
                        e.status = 2'b11;
                    end
                end
                DEL: begin
                    if (hit >= 0) begin
                        e.value    = m_val[hit];
                        e.index    = hit[IW-1:0];
                        m_vld[hit] = 1'b0;
                        m_count--;
                    end else begin
                        e.status = 2'b10;
                    end
                end
                LKP: begin
                    if (hit >= 0) begin
                        e.value = m_val[hit];
                        e.index = hit[IW-1:0];
                    end else begin
                        e.status = 2'b10;
                    end
                end
                CLR: modelClear();
                default: ;
            endcase
            if (o >= INS && o <= CLR) exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        op       = NOP;
    endtask

    task automatic waitDrain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin
            @(posedge clk);
            #2;
            guard++;
        end
        checkValue("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkCount(input string tag);
        checkValue({tag, "_count"}, 32'(count_out), 32'(m_count));
        checkValue({tag, "_full"},  32'(full),      32'(m_count == MS));
        checkValue({tag, "_empty"}, 32'(empty),     32'(m_count == 0));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        op       = NOP;
        key_in   = '0;
        value_in = '0;
        modelClear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        checkValue("rst_valid_out", 32'(valid_out),  32'd0);
        checkValue("rst_ready_out", 32'(ready_out),  32'd1);
        checkValue("rst_status",    32'(status_out), 32'd0);
        checkValue("rst_value",     32'(value_out),  32'd0);
        checkValue("rst_index",     32'(index_out),  32'd0);
        checkCount("rst");

        // Basic insert / lookup / update
        applyStimulus(INS, 8'h05, 16'h1234);
        applyStimulus(LKP, 8'h05, 16'h0000);
        checkCount("basic");
        applyStimulus(INS, 8'h05, 16'hBEEF);
        checkCount("update");
        applyStimulus(LKP, 8'h05, 16'h0000);

        // Absent key, then clear
        applyStimulus(DEL, 8'h77, 16'h0000);
        applyStimulus(LKP, 8'h77, 16'h0000);
        applyStimulus(CLR, 8'h00, 16'h0000);
        checkCount("clear");
        applyStimulus(LKP, 8'h05, 16'h0000);

        // Fill to capacity, overflow, update while full, free slot 3 and reuse
        for (int i = 0; i < MS; i++) applyStimulus(INS, 8'(8'h10 + i), 16'(16'h0100 + i));
        checkCount("filled");
        applyStimulus(INS, 8'h99, 16'hAAAA);
        checkCount("overflow");
        applyStimulus(INS, 8'h12, 16'h2222);
        applyStimulus(DEL, 8'h13, 16'h0000);
        checkCount("del_slot3");
        applyStimulus(INS, 8'h99, 16'hAAAA);
        checkCount("refill");
        applyStimulus(LKP, 8'h12, 16'h0000);
        waitDrain();

        // Reserved opcode acts as NOP; back-to-back insert then lookup
        applyStimulus(CLR, 8'h00, 16'h0000);
        applyStimulus(3'b101, 8'h21, 16'h0055);
        checkCount("nop");
        applyStimulus(INS, 8'h21, 16'h0055);
        applyStimulus(LKP, 8'h21, 16'h0000);
        waitDrain();

        // Backpressure: held response with a pending request
        ready_in = 1'b0;
        applyStimulus(INS, 8'h40, 16'h0A0A);
        valid_in = 1'b1;
        op       = INS;
        key_in   = 8'h41;
        value_in = 16'h0B0B;
        repeat (3) begin
            @(negedge clk);
            checkValue("hold_ready_out", 32'(ready_out),  32'd0);
            checkValue("hold_valid_out", 32'(valid_out),  32'd1);
            checkValue("hold_status",    32'(status_out), 32'(exp_q[0].status));
            checkValue("hold_value",     32'(value_out),  32'(exp_q[0].value));
            checkValue("hold_index",     32'(index_out),  32'(exp_q[0].index));
            checkValue("hold_count",     32'(count_out),  32'(m_count));
        end
        @(posedge clk);
        #1;
        ready_in = 1'b1;
        applyStimulus(INS, 8'h41, 16'h0B0B);
        applyStimulus(LKP, 8'h40, 16'h0000);
        waitDrain();
        checkCount("after_hold");

        // Reset mid-stream with a held response and a request in flight
        ready_in = 1'b0;
        applyStimulus(INS, 8'h50, 16'h5050);
        checkValue("pre_reset_valid_out", 32'(valid_out), 32'd1);
        reset_n  = 1'b0;
        valid_in = 1'b1;
        op       = INS;
        key_in   = 8'h51;
        value_in = 16'h5151;
        @(posedge clk);
        #1;
        reset_n  = 1'b1;
        valid_in = 1'b0;
        op       = NOP;
        exp_q.delete();
        modelClear();
        checkValue("mid_rst_valid_out", 32'(valid_out), 32'd0);
        checkValue("mid_rst_ready_out", 32'(ready_out), 32'd1);
        checkCount("mid_rst");
        ready_in = 1'b1;
        applyStimulus(LKP, 8'h50, 16'h0000);
        applyStimulus(LKP, 8'h51, 16'h0000);
        applyStimulus(INS, 8'h60, 16'h6060);
        checkCount("post_rst");
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
